// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard issue interface: the decoded instruction and flush
// flow into the scoreboard; the stall/issue handshake, writeback select and
// status flow back out.
interface issue_scoreboard_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_writes_rd;
    logic [1:0]  id_fu;
    logic        flush;
    logic        stall;
    logic        issue;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_fu;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_fu, flush,
        input  stall, issue, wb_valid, wb_rd, wb_fu, busy_mask, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_fu, flush,
        output stall, issue, wb_valid, wb_rd, wb_fu, busy_mask, stall_count
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard for the in-order-issue, out-of-order-completion core.
// Keeps a pending bit per architectural register and a shift register of
// write-port reservations indexed by cycles-until-writeback. Decode stalls
// on RAW, WAW and write-port collisions; slot 0 drives the writeback mux.
module issue_scoreboard #(
    parameter int ALU_LAT = 1,
    parameter int MEM_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int MAXLAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    issue_scoreboard_if.slave sb
);

    localparam int LW = $clog2(MAXLAT + 1);

    logic [31:0]       pending_r;
    logic [31:0]       pending_next_s;
    logic [MAXLAT-1:0] res_v_r;
    logic [4:0]        res_rd_r [MAXLAT];
    logic [1:0]        res_fu_r [MAXLAT];
    logic [15:0]       stall_count_r;

    logic [LW-1:0]     lat_s;
    logic              wr_s;
    logic              raw_s;
    logic              waw_s;
    logic              port_s;
    logic              stall_s;
    logic              issue_s;
    logic              reserve_s;

    // Unit code to result latency; the reserved code 3 behaves as ALU.
    function automatic logic [LW-1:0] fu_latency(input logic [1:0] fu);
        case (fu)
            2'd1:    fu_latency = LW'(MUL_LAT);
            2'd2:    fu_latency = LW'(MEM_LAT);
            default: fu_latency = LW'(ALU_LAT);
        endcase
    endfunction

    // Hazard detection and the issue/stall decision for the decode slot.
    always_comb begin
        lat_s  = fu_latency(sb.id_fu);
        wr_s   = sb.id_writes_rd && (sb.id_rd != 5'd0);
        raw_s  = (sb.id_uses_rs1 && pending_r[sb.id_rs1]) ||
                 (sb.id_uses_rs2 && pending_r[sb.id_rs2]);
        waw_s  = wr_s && pending_r[sb.id_rd];
        // A latency equal to MAXLAT matches no slot, so it reads as free.
        port_s = 1'b0;
        for (int k = 0; k < MAXLAT; k++) begin
            port_s = port_s | (wr_s & res_v_r[k] & (LW'(k) == lat_s));
        end
        stall_s   = sb.id_valid && !sb.flush && (raw_s || waw_s || port_s);
        issue_s   = sb.id_valid && !sb.flush && !stall_s;
        reserve_s = issue_s && wr_s;
    end

    // Next pending mask: writeback clears, a new issue sets (set wins).
    always_comb begin
        pending_next_s = pending_r;
        if (res_v_r[0]) begin
            pending_next_s[res_rd_r[0]] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (reserve_s) begin
            pending_next_s[sb.id_rd] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
        pending_next_s[0] = 1'b0;
    end

    // Reservation shift register: advance one slot per cycle and book the
    // slot that reaches index 0 exactly L cycles after issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_v_r <= '0;
            for (int k = 0; k < MAXLAT; k++) begin
                res_rd_r[k] <= 5'd0;
                res_fu_r[k] <= 2'd0;
            end
        end else begin
            for (int k = 0; k < MAXLAT - 1; k++) begin
                res_v_r[k]  <= res_v_r[k+1];
                res_rd_r[k] <= res_rd_r[k+1];
                res_fu_r[k] <= res_fu_r[k+1];
            end
            res_v_r[MAXLAT-1]  <= 1'b0;
            res_rd_r[MAXLAT-1] <= 5'd0;
            res_fu_r[MAXLAT-1] <= 2'd0;
            if (reserve_s) begin
                for (int k = 0; k < MAXLAT; k++) begin
                    if (LW'(k + 1) == lat_s) begin
                        res_v_r[k]  <= 1'b1;
                        res_rd_r[k] <= sb.id_rd;
                        res_fu_r[k] <= sb.id_fu;
                    end
                end
            end
        end
    end

    // Pending register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Saturating stall cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= 16'd0;
        end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end
    end

    assign sb.stall       = stall_s;
    assign sb.issue       = issue_s;
    assign sb.wb_valid    = res_v_r[0];
    assign sb.wb_rd       = res_rd_r[0];
    assign sb.wb_fu       = res_fu_r[0];
    assign sb.busy_mask   = pending_r;
    assign sb.stall_count = stall_count_r;

endmodule
